// File: rtl/icache_lined_pkg.sv
// Shared definitions for the lined instruction cache: default geometry, FSM states
// and address-field width helpers (TAG | IDX | OFF | byte).
package icache_lined_pkg;

  localparam int ICACHE_ADDR_W     = 32;
  localparam int ICACHE_WORD_W     = 32;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_SETS       = 64;
  localparam int BYTE_OFF_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } icache_state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - BYTE_OFF_W - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data store for the instruction cache: one write port, one registered read port.
// A read of the word being written in the same cycle returns the new data.
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/icache_lined.sv
// Direct-mapped instruction cache with multi-word lines, refilled word-by-word from mem_ctrl.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters on perf_hits/perf_misses.
module icache_lined
  import icache_lined_pkg::*;
#(
  parameter int ADDR_W     = ICACHE_ADDR_W,
  parameter int WORD_W     = ICACHE_WORD_W,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int SETS       = ICACHE_SETS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [WORD_W-1:0] if_instr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  logic [OFF_W-1:0] if_off;
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             unused_addr_bits;

  assign if_off = if_addr[BYTE_OFF_W +: OFF_W];
  assign if_idx = if_addr[BYTE_OFF_W + OFF_W +: IDX_W];
  assign if_tag = if_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = &{1'b0, if_addr[BYTE_OFF_W-1:0]};

  icache_state_e    state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             abort_q, abort_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic             if_ack_q, if_ack_d;
  logic             mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0] tag_mem_q [SETS];
  logic             tag_we;
  logic             hit;
  logic             accept;

  logic              ram_we, ram_re;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;

  assign hit     = valid_q[if_idx] && (tag_mem_q[if_idx] == if_tag);
  // The cycle right after an ack never accepts, so acks can never come back-to-back.
  assign accept  = rdy && (state_q == ST_IDLE) && !flush && if_req && !if_ack_q;
  assign cnt_nxt = cnt_q + OFF_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    off_d      = off_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    if_ack_d   = if_ack_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    tag_we     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = {idx_q, cnt_q};
    ram_raddr  = {if_idx, if_off};
    if (rdy) begin
      if_ack_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (flush) begin
            valid_d = '0;
          end else if (accept && hit) begin
            if_ack_d = 1'b1;
            ram_re   = 1'b1;
          end else if (accept) begin
            state_d         = ST_REFILL;
            mem_req_d       = 1'b1;
            mem_addr_d      = {if_tag, if_idx, {OFF_W{1'b0}}, 2'b00};
            idx_d           = if_idx;
            tag_d           = if_tag;
            off_d           = if_off;
            abort_d         = 1'b0;
            valid_d[if_idx] = 1'b0;
          end
        end
        ST_REFILL: begin
          if (flush) begin
            valid_d = '0;
            abort_d = 1'b1;
          end
          if (mem_valid) begin
            ram_we = 1'b1;
            if (abort_q || flush) begin
              // Outstanding word has been drained; abandon the line.
              state_d   = ST_IDLE;
              mem_req_d = 1'b0;
              cnt_d     = '0;
            end else if (cnt_q == CNT_LAST) begin
              mem_req_d      = 1'b0;
              tag_we         = 1'b1;
              valid_d[idx_q] = 1'b1;
              cnt_d          = '0;
              if (if_req) begin
                state_d   = ST_RESP;
                if_ack_d  = 1'b1;
                ram_re    = 1'b1;
                ram_raddr = {idx_q, off_q};
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d      = cnt_nxt;
              mem_addr_d = {tag_q, idx_q, cnt_nxt, 2'b00};
            end
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
          if (flush) begin
            valid_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      off_q      <= '0;
      abort_q    <= 1'b0;
      valid_q    <= '0;
      if_ack_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      off_q      <= off_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
      if_ack_q   <= if_ack_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem_q[idx_q] <= tag_q;
    end
  end

  icache_data_ram #(
    .DEPTH (SETS * LINE_WORDS),
    .AW    (RAM_AW),
    .DW    (WORD_W)
  ) u_data_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (mem_rdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (if_instr)
  );

  assign if_ack   = if_ack_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (accept && hit && (hits_q != 32'hFFFF_FFFF)) begin
      hits_d = hits_q + 32'd1;
    end
    if (accept && !hit && (misses_q != 32'hFFFF_FFFF)) begin
      misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_lined.sv
// Directed bench for icache_lined: table of fetches plus hand sequences for
// back-to-back acks, flush, slow memory with rdy gaps, branch redirect and reset mid-refill.
module tb_icache_lined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  icache_lined dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_instr  (if_instr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_vld_cyc = 0;
  int ack_cyc = 0;
  int mem_delay = 0;
  int wait_cnt = 0;
  logic [31:0] mlog[$];

  always @(posedge clk) cyc++;

  // Memory model: answers the current mem_addr after mem_delay cycles; while rdy=0 it
  // shows a junk word that the cache must ignore and retries later.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (!rst_n || !mem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt < mem_delay) begin
      wait_cnt++;
    end else begin
      mem_valid = 1'b1;
      if (rdy) begin
        mem_rdata = 32'hC0DE_0000 | {16'h0000, mem_addr[15:0]};
        mlog.push_back(mem_addr);
        last_vld_cyc = cyc + 1;
        wait_cnt = 0;
      end else begin
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit exp_miss,
                       input string nm);
    int n;
    bit saw;
    bit got;
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    saw = 1'b0;
    got = 1'b0;
    while (!got && n < 300) begin
      step();
      n++;
      if (mem_req) saw = 1'b1;
      if (if_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    chk({nm, " ack"}, {31'b0, got}, 32'd1);
    if (got) chk({nm, " data"}, if_instr, exp);
    chk({nm, " miss"}, {31'b0, saw}, {31'b0, exp_miss});
    if (!exp_miss) chk({nm, " hit latency"}, n, 32'd1);
    if_req = 1'b0;
    step();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    bit acked;
    vecs[0] = '{32'h0000_100C, 32'hC0DE_100C, 1'b0};
    vecs[1] = '{32'h0000_1008, 32'hC0DE_1008, 1'b0};
    vecs[2] = '{32'h0000_1400, 32'hC0DE_1400, 1'b1};
    vecs[3] = '{32'h0000_1000, 32'hC0DE_1000, 1'b1};
    vecs[4] = '{32'h0000_1404, 32'hC0DE_1404, 1'b1};
    vecs[5] = '{32'h0000_2010, 32'hC0DE_2010, 1'b1};
    vecs[6] = '{32'h0000_2014, 32'hC0DE_2014, 1'b0};
    vecs[7] = '{32'h0000_1408, 32'hC0DE_1408, 1'b0};

    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset if_ack", {31'b0, if_ack}, 32'd0);
    chk("reset if_instr", if_instr, 32'd0);
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);

    // Cold miss: whole line from offset 0, ack one cycle after the last word.
    mlog.delete();
    fetch(32'h0000_1004, 32'hC0DE_1004, 1'b1, "cold");
    chk("cold words", mlog.size(), 32'd4);
    for (int i = 0; i < 4 && i < mlog.size(); i++)
      chk("cold order", mlog[i], 32'h0000_1000 + 32'(4 * i));
    chk("cold ack timing", ack_cyc, last_vld_cyc);

    for (int i = 0; i < 8; i++)
      fetch(vecs[i].addr, vecs[i].data, vecs[i].miss, $sformatf("vec%0d", i));

    // Request held across an ack: next ack must skip a cycle.
    if_addr = 32'h0000_2014;
    if_req  = 1'b1;
    step();
    chk("b2b first ack", {31'b0, if_ack}, 32'd1);
    step();
    chk("b2b gap", {31'b0, if_ack}, 32'd0);
    step();
    chk("b2b second ack", {31'b0, if_ack}, 32'd1);
    chk("b2b data", if_instr, 32'hC0DE_2014);
    if_req = 1'b0;
    step();

    // Flush overrides a same-cycle hit; the held request then misses.
    fetch(32'h0000_1000, 32'hC0DE_1000, 1'b1, "pre-flush");
    if_addr = 32'h0000_1000;
    if_req  = 1'b1;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    chk("flush hit no ack", {31'b0, if_ack}, 32'd0);
    fetch(32'h0000_1000, 32'hC0DE_1000, 1'b1, "post-flush");

    // Branch redirect mid-refill: no ack, but the line ends up valid.
    mem_delay = 2;
    mlog.delete();
    if_addr = 32'h0000_6000;
    if_req  = 1'b1;
    n = 0;
    while (mlog.size() < 1 && n < 50) begin step(); n++; end
    if_req = 1'b0;
    acked = 1'b0;
    n = 0;
    while (mem_req && n < 100) begin step(); n++; if (if_ack) acked = 1'b1; end
    step();
    if (if_ack) acked = 1'b1;
    chk("redirect refill done", {31'b0, mem_req}, 32'd0);
    chk("redirect no ack", {31'b0, acked}, 32'd0);
    chk("redirect words", mlog.size(), 32'd4);
    fetch(32'h0000_6004, 32'hC0DE_6004, 1'b0, "redirect line");

    // Flush mid-refill: drain, no ack, line not kept.
    mlog.delete();
    if_addr = 32'h0000_7000;
    if_req  = 1'b1;
    n = 0;
    while (mlog.size() < 1 && n < 50) begin step(); n++; end
    flush  = 1'b1;
    if_req = 1'b0;
    step();
    flush = 1'b0;
    acked = if_ack;
    n = 0;
    while (mem_req && n < 100) begin step(); n++; if (if_ack) acked = 1'b1; end
    chk("flush refill stopped", {31'b0, mem_req}, 32'd0);
    chk("flush refill no ack", {31'b0, acked}, 32'd0);
    chk("flush refill short", {31'b0, (mlog.size() < 4)}, 32'd1);
    mlog.delete();
    fetch(32'h0000_7000, 32'hC0DE_7000, 1'b1, "after flush refill");
    chk("after flush words", mlog.size(), 32'd4);

    // Slow memory with rdy gaps: exactly four words, correct contents.
    mem_delay = 5;
    mlog.delete();
    if_addr = 32'h0000_3004;
    if_req  = 1'b1;
    acked = 1'b0;
    n = 0;
    while (!acked && n < 400) begin
      step();
      n++;
      if (if_ack) acked = 1'b1;
      else rdy = ((n % 7) != 3) && ((n % 7) != 4);
    end
    chk("slow ack", {31'b0, acked}, 32'd1);
    chk("slow data", if_instr, 32'hC0DE_3004);
    rdy = 1'b1;
    if_req = 1'b0;
    step();
    chk("slow words", mlog.size(), 32'd4);
    for (int i = 0; i < 4 && i < mlog.size(); i++)
      chk("slow order", mlog[i], 32'h0000_3000 + 32'(4 * i));
    fetch(32'h0000_300C, 32'hC0DE_300C, 1'b0, "slow word3");
    fetch(32'h0000_3000, 32'hC0DE_3000, 1'b0, "slow word0");

    // Async reset mid-refill.
    mem_delay = 3;
    mlog.delete();
    if_addr = 32'h0000_5008;
    if_req  = 1'b1;
    n = 0;
    while (mlog.size() < 2 && n < 100) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    chk("rst mid if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst mid if_instr", if_instr, 32'd0);
    chk("rst mid mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst mid mem_addr", mem_addr, 32'd0);
    if_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    mem_delay = 0;
    mlog.delete();
    fetch(32'h0000_5008, 32'hC0DE_5008, 1'b1, "after reset");
    chk("after reset words", mlog.size(), 32'd4);
    if (mlog.size() == 4) begin
      chk("after reset first", mlog[0], 32'h0000_5000);
      chk("after reset last", mlog[3], 32'h0000_500C);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
